board_draw_engine: RTL and testbench

- Responder side of the game FSM's "display board" request.
- The game FSM raises a draw request for board 1 or board 2. This block scans that board's cell storage in raster order and streams each cell into the frame-buffer write port, then pulses done.
- Sits between the game-state registers/RAM and the frame buffer feeding the VGA path.

---
 rtl/board_draw_engine.sv | 114 +++++++++++
 tb/tb_board_draw_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_draw_engine.sv
// Streams one board's cell storage, in raster order, into the frame-buffer write port.
// Define BOARD_DRAW_SKIP_EMPTY_EN to suppress writes of empty cells and add write_count.
module board_draw_engine #(
  parameter int BOARD_W   = 10,
  parameter int BOARD_H   = 10,
  parameter int CELL_BITS = 2,
  parameter int ADDR_W    = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 draw_req,
  input  logic                 board_sel,
  output logic [ADDR_W-1:0]    cell_addr,
  output logic                 board_rd,
  input  logic [CELL_BITS-1:0] cell_data,
  output logic                 fb_we,
  output logic [ADDR_W-1:0]    fb_addr,
  output logic [CELL_BITS-1:0] fb_data,
  output logic                 busy,
  output logic                 draw_done
`ifdef BOARD_DRAW_SKIP_EMPTY_EN
  ,
  output logic [ADDR_W-1:0]    write_count
`endif
);

  localparam logic [ADDR_W-1:0] NUM_CELLS = ADDR_W'(BOARD_W * BOARD_H);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(BOARD_W * BOARD_H - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic              issue_q;
  logic              wr_valid;
  logic              last_issued;

  // The final read address has been on cell_addr for a cycle; nothing left to issue.
  assign last_issued = issue_q && (cell_addr == LAST_CELL);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      counter   <= '0;
      issue_q   <= 1'b0;
      wr_valid  <= 1'b0;
      cell_addr <= '0;
      board_rd  <= 1'b0;
      fb_addr   <= '0;
      busy      <= 1'b0;
      draw_done <= 1'b0;
`ifdef BOARD_DRAW_SKIP_EMPTY_EN
      write_count <= '0;
`endif
    end else begin
      issue_q   <= 1'b0;
      wr_valid  <= issue_q;
      draw_done <= 1'b0;
      if (issue_q) begin
        fb_addr <= (board_rd ? NUM_CELLS : '0) + cell_addr;
      end
`ifdef BOARD_DRAW_SKIP_EMPTY_EN
      if (wr_valid && (cell_data != '0)) begin
        write_count <= write_count + 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (draw_req) begin
            board_rd <= board_sel;
            busy     <= 1'b1;
            counter  <= '0;
            state    <= STREAM;
`ifdef BOARD_DRAW_SKIP_EMPTY_EN
            write_count <= '0;
`endif
          end
        end
        STREAM: begin
          if (last_issued) begin
            state <= FLUSH;
          end else begin
            cell_addr <= counter;
            issue_q   <= 1'b1;
            if (counter != LAST_CELL) begin
              counter <= counter + 1'b1;
            end
          end
        end
        FLUSH: begin
          busy      <= 1'b0;
          draw_done <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data only arrives in the write cycle itself, so it is forwarded rather than re-registered.
  assign fb_data = wr_valid ? cell_data : '0;

`ifdef BOARD_DRAW_SKIP_EMPTY_EN
  assign fb_we = wr_valid && (cell_data != '0);
`else
  assign fb_we = wr_valid;
`endif

endmodule

// File: tb/tb_board_draw_engine.sv
// Self-checking bench for board_draw_engine (4x4 board) with a cycle-indexed reference model.
// Honours BOARD_DRAW_SKIP_EMPTY_EN the same way as the design.
module tb_board_draw_engine;

  localparam int N      = 16;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              draw_req = 1'b0;
  logic              board_sel = 1'b0;
  logic [ADDR_W-1:0] cell_addr;
  logic              board_rd;
  logic [1:0]        cell_data = 2'd0;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [1:0]        fb_data;
  logic              busy;
  logic              draw_done;
`ifdef BOARD_DRAW_SKIP_EMPTY_EN
  logic [ADDR_W-1:0] write_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] mem [0:1][0:N-1];

  board_draw_engine #(
    .BOARD_W(4), .BOARD_H(4), .CELL_BITS(2), .ADDR_W(ADDR_W)
  ) dut (
    .Clk(clk), .Reset(rst), .draw_req(draw_req), .board_sel(board_sel),
    .cell_addr(cell_addr), .board_rd(board_rd), .cell_data(cell_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .draw_done(draw_done)
`ifdef BOARD_DRAW_SKIP_EMPTY_EN
    , .write_count(write_count)
`endif
  );

  always #5 clk = ~clk;

  // Board storage with one cycle of read latency.
  always @(posedge clk) begin
    cell_data <= (cell_addr < ADDR_W'(N)) ? mem[board_rd][cell_addr[3:0]] : 2'd0;
  end

  // Reference model: phase is the cycle number relative to the acceptance edge, -1 when idle.
  int   phase  = -1;
  logic exp_sel = 1'b0;
  int   exp_ca = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   = -1;
      exp_sel = 1'b0;
      exp_ca  = 0;
    end else begin
      if (phase >= 0) begin
        phase++;
        if (phase == N + 3) phase = -1;
      end else if (draw_req) begin
        phase   = 0;
        exp_sel = board_sel;
      end
      if (phase >= 1 && phase <= N) exp_ca = phase - 1;
    end
  end

  function automatic int nonzero_cells(input logic sel);
    int cnt = 0;
    for (int k = 0; k < N; k++) if (mem[sel][k] != 2'd0) cnt++;
    return cnt;
  endfunction

  function automatic int expected_writes(input logic sel);
`ifdef BOARD_DRAW_SKIP_EMPTY_EN
    return nonzero_cells(sel);
`else
    return N;
`endif
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit in_write;
    bit exp_we;
    int k;
    in_write = (phase >= 2) && (phase <= N + 1);
    k        = in_write ? phase - 2 : 0;
    exp_we   = in_write;
`ifdef BOARD_DRAW_SKIP_EMPTY_EN
    exp_we   = in_write && (mem[exp_sel][k] != 2'd0);
`endif
    check_output("busy", 32'(busy), 32'((phase >= 0) && (phase <= N + 1)));
    check_output("draw_done", 32'(draw_done), 32'(phase == N + 2));
    check_output("cell_addr", 32'(cell_addr), 32'(exp_ca));
    check_output("board_rd", 32'(board_rd), 32'(exp_sel));
    check_output("fb_we", 32'(fb_we), 32'(exp_we));
    if (in_write) begin
      check_output("fb_addr", 32'(fb_addr), 32'((exp_sel ? N : 0) + k));
      check_output("fb_data", 32'(fb_data), 32'(mem[exp_sel][k]));
    end
`ifdef BOARD_DRAW_SKIP_EMPTY_EN
    if (phase == N + 2) check_output("write_count", 32'(write_count), 32'(nonzero_cells(exp_sel)));
`endif
  end

  task automatic fill_pattern();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < N; k++) mem[b][k] = 2'(k % 4);
  endtask

  task automatic fill_random();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < N; k++) mem[b][k] = 2'($urandom_range(0, 3));
  endtask

  // Called 1 time unit after an edge while idle; returns 1 time unit after the acceptance edge.
  task automatic apply_stimulus(input logic sel);
    draw_req  = 1'b1;
    board_sel = sel;
    @(posedge clk);
    #1;
    draw_req = 1'b0;
    check_output("accept_busy", 32'(busy), 32'd1);
  endtask

  // Follows a draw from cycle 0 through idle, counting writes and done pulses.
  task automatic track_draw(input int exp_writes, input bit toggle, input bit repulse, input logic sel);
    int writes  = 0;
    int dones   = 0;
    int done_c  = -1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk);
      #1;
      if (toggle && c == 5) board_sel = ~sel;
      if (repulse && (c == 4 || c == 10)) draw_req = 1'b1;
      if (repulse && (c == 5 || c == 11)) draw_req = 1'b0;
      if (c == 1) check_output("first_cell_addr", 32'(cell_addr), 32'd0);
      if (c == 2) check_output("first_fb_addr", 32'(fb_addr), sel ? 32'd16 : 32'd0);
      if (fb_we) writes++;
      if (draw_done) begin
        dones++;
        if (done_c < 0) done_c = c;
      end
    end
    check_output("write_total", 32'(writes), 32'(exp_writes));
    check_output("done_cycle", 32'(done_c), 32'd18);
    check_output("done_count", 32'(dones), 32'd1);
  endtask

  initial begin
    bit   seen;
    logic sel;
    int   pattern_writes;
`ifdef BOARD_DRAW_SKIP_EMPTY_EN
    pattern_writes = 12;
`else
    pattern_writes = 16;
`endif
    fill_pattern();

    // Reset with a request already pending.
    #1;
    rst      = 1'b1;
    draw_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_fb_we", 32'(fb_we), 32'd0);
    check_output("rst_cell_addr", 32'(cell_addr), 32'd0);
    check_output("rst_done", 32'(draw_done), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("accept_after_rst", 32'(busy), 32'd1);
    draw_req = 1'b0;
    track_draw(pattern_writes, 1'b0, 1'b0, 1'b0);
`ifdef BOARD_DRAW_SKIP_EMPTY_EN
    check_output("write_count_hold", 32'(write_count), 32'd12);
`endif

    // Board 2 with board_sel toggled mid-draw.
    apply_stimulus(1'b1);
    track_draw(pattern_writes, 1'b1, 1'b0, 1'b1);

    // Requests during a draw are ignored.
    apply_stimulus(1'b0);
    track_draw(pattern_writes, 1'b0, 1'b1, 1'b0);

    // Reset in cycle 8 aborts the draw.
    apply_stimulus(1'b1);
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_output("abort_fb_we", 32'(fb_we), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(draw_done), 32'd0);
    check_output("abort_cell_addr", 32'(cell_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    apply_stimulus(1'b0);
    track_draw(pattern_writes, 1'b0, 1'b0, 1'b0);

    // Request held high across done: one idle cycle before the next acceptance.
    draw_req  = 1'b1;
    board_sel = 1'b0;
    seen      = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (draw_done) seen = 1'b1;
    end
    check_output("b2b_done_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    check_output("b2b_gap_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check_output("b2b_reaccept_busy", 32'(busy), 32'd1);
    draw_req = 1'b0;
    track_draw(pattern_writes, 1'b0, 1'b0, 1'b0);

    // Randomized board contents, board selection and disturbances.
    for (int i = 0; i < 8; i++) begin
      fill_random();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      sel = 1'($urandom_range(0, 1));
      apply_stimulus(sel);
      track_draw(expected_writes(sel), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sel);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
